// File: rtl/hamming_mon_pkg.sv
// Shared types for the Hamming(7,4) error monitor: FSM states, report kinds,
// syndrome codes and the syndrome-to-kind decode.
package hamming_mon_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        SCAN   = 3'd2,
        REPORT = 3'd3,
        DONE   = 3'd4
    } mon_state_t;

    typedef enum logic [1:0] {
        KIND_NONE   = 2'd0,
        KIND_DATA   = 2'd1,
        KIND_PARITY = 2'd2
    } err_kind_t;

    localparam logic [2:0] SYN_NONE = 3'b000;
    localparam logic [2:0] SYN_P0   = 3'b001;
    localparam logic [2:0] SYN_P1   = 3'b010;
    localparam logic [2:0] SYN_P2   = 3'b100;

    // A single-bit syndrome points at a parity bit; any other nonzero code is a data bit.
    function automatic err_kind_t kind_of(input logic [2:0] syn);
        err_kind_t k;
        case (syn)
            SYN_NONE:               k = KIND_NONE;
            SYN_P0, SYN_P1, SYN_P2: k = KIND_PARITY;
            default:                k = KIND_DATA;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/hamming_error_monitor_if.sv
// Error-log report channel: valid/ready handshake carrying block index, syndrome and kind.
// Payload is held stable by the master while err_valid is high and err_ready is low.
interface hamming_error_monitor_if #(
    parameter int BLOCK_W = 2
);
    import hamming_mon_pkg::*;

    logic               err_valid;
    logic               err_ready;
    logic [BLOCK_W-1:0] err_block;
    logic [2:0]         err_syndrome;
    err_kind_t          err_kind;

    modport master (
        output err_valid,
        output err_block,
        output err_syndrome,
        output err_kind,
        input  err_ready
    );

    modport slave (
        input  err_valid,
        input  err_block,
        input  err_syndrome,
        input  err_kind,
        output err_ready
    );

endinterface

// File: rtl/hamming74_syndrome.sv
// Combinational Hamming(7,4) syndrome of one data nibble against its stored parity triple.
// Zero latency, no handshake.
module hamming74_syndrome (
    input  logic [3:0] data,
    input  logic [2:0] parity,
    output logic [2:0] syn
);

    assign syn[0] = parity[0] ^ data[3] ^ data[2] ^ data[0];
    assign syn[1] = parity[1] ^ data[3] ^ data[1] ^ data[0];
    assign syn[2] = parity[2] ^ data[2] ^ data[1] ^ data[0];

endmodule

// File: rtl/hamming_error_monitor.sv
// Snapshots counter+parity on enable fall, scans one nibble per cycle, reports errors over valid/ready
// (stalls in REPORT until accepted; clean scan_done = BLOCKS+2 cycles). HAMMING_MON_IRQ_EN adds irq_thresh/irq.
module hamming_error_monitor
    import hamming_mon_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int BLOCKS      = WIDTH / 4,
    parameter int PARITY_BITS = BLOCKS * 3,
    parameter int CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [WIDTH-1:0]           counter,
    input  logic [PARITY_BITS-1:0]     parity_stored,
    hamming_error_monitor_if.master    err,
    output logic                       scan_done,
    output logic                       overrun,
    output logic [CNT_W-1:0]           err_count
`ifdef HAMMING_MON_IRQ_EN
    ,
    input  logic [CNT_W-1:0]           irq_thresh,
    output logic                       irq
`endif
);

    localparam int                IDX_W    = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BLOCKS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    mon_state_t             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   enable_q;
    logic [WIDTH-1:0]       snap_cnt_q;
    logic [PARITY_BITS-1:0] snap_par_q;
    logic                   err_valid_q;
    logic [IDX_W-1:0]       err_block_q;
    logic [2:0]             err_syn_q;
    err_kind_t              err_kind_q;
    logic                   scan_done_q;
    logic                   overrun_q;
    logic [CNT_W-1:0]       err_count_q;
    logic [CNT_W-1:0]       err_count_inc;

    logic       fall;
    logic       accept;
    logic [3:0] blk_dat;
    logic [2:0] blk_par;
    logic [2:0] syn;

    assign fall    = enable_q & ~enable;
    assign accept  = err_valid_q & err.err_ready;
    assign blk_dat = snap_cnt_q[int'(idx_q) * 4 +: 4];
    assign blk_par = snap_par_q[int'(idx_q) * 3 +: 3];

    hamming74_syndrome u_syn (
        .data   (blk_dat),
        .parity (blk_par),
        .syn    (syn)
    );

    assign err_count_inc = (err_count_q == CNT_MAX) ? err_count_q : err_count_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (fall) state_d = ARM;
            end
            ARM: begin
                state_d = SCAN;
                idx_d   = '0;
            end
            SCAN: begin
                if (syn != SYN_NONE) begin
                    state_d = REPORT;
                end else if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            REPORT: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d = SCAN;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            enable_q    <= 1'b0;
            snap_cnt_q  <= '0;
            snap_par_q  <= '0;
            err_valid_q <= 1'b0;
            err_block_q <= '0;
            err_syn_q   <= '0;
            err_kind_q  <= KIND_NONE;
            scan_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            enable_q    <= enable;
            scan_done_q <= (state_q == DONE);

            // Parity has had the ARM cycle to settle; later enable activity cannot touch the copy.
            if (state_q == ARM) begin
                snap_cnt_q <= counter;
                snap_par_q <= parity_stored;
            end

            if (state_q == SCAN && syn != SYN_NONE) begin
                err_valid_q <= 1'b1;
                err_block_q <= idx_q;
                err_syn_q   <= syn;
                err_kind_q  <= kind_of(syn);
            end else if (accept) begin
                err_valid_q <= 1'b0;
            end

            if (fall && state_q != IDLE) overrun_q <= 1'b1;
            if (accept) err_count_q <= err_count_inc;
        end
    end

`ifdef HAMMING_MON_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else if (accept && irq_thresh != '0 && err_count_inc >= irq_thresh) begin
            irq_q <= 1'b1;
        end
    end

    assign irq = irq_q;
`endif

    assign err.err_valid    = err_valid_q;
    assign err.err_block    = err_block_q;
    assign err.err_syndrome = err_syn_q;
    assign err.err_kind     = err_kind_q;
    assign scan_done        = scan_done_q;
    assign overrun          = overrun_q;
    assign err_count        = err_count_q;

endmodule

// File: tb/tb_hamming_error_monitor.sv
// Directed bench for hamming_error_monitor (CNT_W=4 so saturation is reachable quickly).
// Builds with or without HAMMING_MON_IRQ_EN.
module tb_hamming_error_monitor;
    import hamming_mon_pkg::*;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [15:0]      counter;
    logic [11:0]      parity_stored;
    logic             scan_done;
    logic             overrun;
    logic [CNT_W-1:0] err_count;
`ifdef HAMMING_MON_IRQ_EN
    logic [CNT_W-1:0] irq_thresh;
    logic             irq;
`endif

    hamming_error_monitor_if #(.BLOCK_W(2)) eif ();

    hamming_error_monitor #(
        .WIDTH (16),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .counter       (counter),
        .parity_stored (parity_stored),
        .err           (eif),
        .scan_done     (scan_done),
        .overrun       (overrun),
        .err_count     (err_count)
`ifdef HAMMING_MON_IRQ_EN
        ,
        .irq_thresh    (irq_thresh),
        .irq           (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    int         lat;
    int         nrep;
    logic [1:0] blk;
    logic [2:0] syn;
    logic [1:0] kind;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one tick after the fall-detect edge.
    task automatic fall(input logic [15:0] c, input logic [11:0] p);
        enable        = 1'b1;
        counter       = c;
        parity_stored = p;
        tick();
        enable = 1'b0;
        tick();
    endtask

    // Counts edges after the fall-detect edge until scan_done; lat_o = -1 if it never comes.
    task automatic wait_done(output int lat_o, output int nrep_o, output logic [1:0] blk_o,
                             output logic [2:0] syn_o, output logic [1:0] kind_o);
        lat_o  = -1;
        nrep_o = 0;
        blk_o  = '0;
        syn_o  = '0;
        kind_o = '0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (eif.err_valid) begin
                nrep_o++;
                blk_o  = eif.err_block;
                syn_o  = eif.err_syndrome;
                kind_o = eif.err_kind;
            end
            if (scan_done) begin
                lat_o = k;
                break;
            end
        end
    endtask

    initial begin
        reset         = 1'b0;
        enable        = 1'b0;
        counter       = '0;
        parity_stored = '0;
        eif.err_ready = 1'b1;
`ifdef HAMMING_MON_IRQ_EN
        irq_thresh    = 4'd5;
`endif
        #12;
        chk("rst_valid",   eif.err_valid, 0);
        chk("rst_done",    scan_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_count",   err_count, 0);
        chk("rst_kind",    eif.err_kind, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // 1: clean data
        fall(16'h0000, 12'h000);
        wait_done(lat, nrep, blk, syn, kind);
        chk("t1_latency", lat, 6);
        chk("t1_reports", nrep, 0);
        chk("t1_count",   err_count, 0);

        // 2: data error in block 1, consumer stalls three cycles
        eif.err_ready = 1'b0;
        fall(16'h0010, 12'h000);
        for (int k = 0; k < 10 && !eif.err_valid; k++) tick();
        chk("t2_valid", eif.err_valid, 1);
        chk("t2_block", eif.err_block, 1);
        chk("t2_syn",   eif.err_syndrome, 3'b111);
        chk("t2_kind",  eif.err_kind, KIND_DATA);
        repeat (3) begin
            tick();
            chk("t2_hold_valid", eif.err_valid, 1);
            chk("t2_hold_block", eif.err_block, 1);
            chk("t2_hold_syn",   eif.err_syndrome, 3'b111);
        end
        chk("t2_count_pre", err_count, 0);
        eif.err_ready = 1'b1;
        tick();
        chk("t2_valid_drop", eif.err_valid, 0);
        chk("t2_count",      err_count, 1);
        wait_done(lat, nrep, blk, syn, kind);
        chk("t2_done", lat > 0, 1);

        // 3: parity error in block 3, consumer always ready
        fall(16'h0000, 12'h200);
        wait_done(lat, nrep, blk, syn, kind);
        chk("t3_reports", nrep, 1);
        chk("t3_block",   blk, 3);
        chk("t3_syn",     syn, 3'b001);
        chk("t3_kind",    kind, KIND_PARITY);
        chk("t3_latency", lat, 7);
        chk("t3_count",   err_count, 2);

        // 4: saturation of the 4-bit counter over 20 faulty scans
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        for (int s = 1; s <= 20; s++) begin
            fall(16'h0010, 12'h000);
            wait_done(lat, nrep, blk, syn, kind);
            chk("t4_reports", nrep, 1);
            chk("t4_count", err_count, (s < 15) ? s : 15);
`ifdef HAMMING_MON_IRQ_EN
            chk("t4_irq", irq, (s >= 5) ? 1 : 0);
`endif
        end

        // 5: second enable fall during SCAN; snapshot must be unaffected
        chk("t5_overrun_pre", overrun, 0);
        fall(16'h0000, 12'h000);
        enable = 1'b1;
        tick();
        enable        = 1'b0;
        counter       = 16'h0010;
        parity_stored = 12'hFFF;
        tick();
        chk("t5_overrun", overrun, 1);
        lat  = -1;
        nrep = 0;
        for (int k = 3; k <= 40; k++) begin
            tick();
            if (eif.err_valid) nrep++;
            if (scan_done) begin
                lat = k;
                break;
            end
        end
        chk("t5_latency", lat, 6);
        chk("t5_reports", nrep, 0);
        chk("t5_count",   err_count, 15);
        counter       = '0;
        parity_stored = '0;

        // 6: asynchronous reset while a report is pending
        eif.err_ready = 1'b0;
        fall(16'h0010, 12'h000);
        for (int k = 0; k < 10 && !eif.err_valid; k++) tick();
        chk("t6_valid_pre", eif.err_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_valid",   eif.err_valid, 0);
        chk("t6_count",   err_count, 0);
        chk("t6_overrun", overrun, 0);
        chk("t6_done",    scan_done, 0);
        @(negedge clk);
        reset         = 1'b1;
        eif.err_ready = 1'b1;
        tick();
        chk("t6_valid_post", eif.err_valid, 0);
        fall(16'h0000, 12'h000);
        wait_done(lat, nrep, blk, syn, kind);
        chk("t6_latency", lat, 6);
        chk("t6_reports", nrep, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_run);
        $fatal(1, "watchdog");
    end

endmodule
